// File: rtl/dyt_rf_pkg.sv
// Shared register-file types: address/data widths and word count.
// Used by the register file and its writeback scheduler.
package dyt_rf_pkg;
   localparam int ADDR_WIDTH = 4;
   localparam int DATA_WIDTH = 32;
   localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
   typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

// File: rtl/dyt_rf_wb_scheduler_if.sv
// Writeback request bus: NUM_REQ valid/ready lanes with packed addr/data slices.
// The master side is the writeback sources, the slave side is the scheduler.
interface dyt_rf_wb_scheduler_if #(
   parameter int NUM_REQ = 2
);
   import dyt_rf_pkg::*;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/dyt_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer.
// The pointer moves past the winner only when the grant is consumed.
module dyt_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] gidx;
   logic          found;

   always_comb begin
      gnt   = '0;
      gidx  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            gidx     = PW'(idx);
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
      end
   end
endmodule

// File: rtl/dyt_rf_wb_scheduler.sv
// Register-file writeback scheduler: round-robin shares the write port,
// registers the write, and tracks pending writes per register.
module dyt_rf_wb_scheduler
   import dyt_rf_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic      clk,
   input  logic      rst,
   dyt_rf_wb_scheduler_if.slave wb,
   input  logic      sb_set_en,
   input  reg_addr_t sb_set_addr,
   output logic      sb_set_rdy,
   input  reg_addr_t q_a_addr,
   input  reg_addr_t q_b_addr,
   output logic      q_a_busy,
   output logic      q_b_busy,
   output logic      w_en,
   output reg_addr_t w_addr,
   output reg_data_t w_data
);
   logic [NUM_REQ-1:0]   gnt;
   logic                 xfer;
   reg_addr_t            sel_addr;
   reg_data_t            sel_data;
   logic [NUM_WORDS-1:0] busy;
   logic [NUM_WORDS-1:0] busy_n;
   logic                 set_fire;

   dyt_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (wb.req_valid),
      .advance (xfer),
      .gnt     (gnt)
   );

   assign wb.req_ready = gnt;
   assign xfer         = |gnt;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // x0 transfers are consumed but never reach the register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_en   <= 1'b0;
         w_addr <= '0;
         w_data <= '0;
      end else begin
         w_en <= xfer && (sel_addr != '0);
         if (xfer) begin
            w_addr <= sel_addr;
            w_data <= sel_data;
         end
      end
   end

   assign sb_set_rdy = !busy[sb_set_addr] || (sb_set_addr == '0);
   assign set_fire   = sb_set_en && sb_set_rdy && (sb_set_addr != '0);

   // set after clear so a new producer wins over the retiring one
   always_comb begin
      busy_n = busy;
      if (w_en) begin
         busy_n[w_addr] = 1'b0;
      end
      if (set_fire) begin
         busy_n[sb_set_addr] = 1'b1;
      end
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_n;
      end
   end

   assign q_a_busy = (q_a_addr != '0) && busy[q_a_addr];
   assign q_b_busy = (q_b_addr != '0) && busy[q_b_addr];
endmodule

// File: tb/tb_dyt_rf_wb_scheduler.sv
// Directed bench for the writeback scheduler: arbitration, write stage,
// scoreboard set/clear and asynchronous reset.
module tb_dyt_rf_wb_scheduler;
   import dyt_rf_pkg::*;

   logic      clk;
   logic      rst;
   logic      sb_set_en;
   reg_addr_t sb_set_addr;
   logic      sb_set_rdy;
   reg_addr_t q_a_addr;
   reg_addr_t q_b_addr;
   logic      q_a_busy;
   logic      q_b_busy;
   logic      w_en;
   reg_addr_t w_addr;
   reg_data_t w_data;

   int checks = 0;
   int errors = 0;

   dyt_rf_wb_scheduler_if #(.NUM_REQ(2)) wb ();

   dyt_rf_wb_scheduler #(
      .NUM_REQ (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wb          (wb),
      .sb_set_en   (sb_set_en),
      .sb_set_addr (sb_set_addr),
      .sb_set_rdy  (sb_set_rdy),
      .q_a_addr    (q_a_addr),
      .q_b_addr    (q_b_addr),
      .q_a_busy    (q_a_busy),
      .q_b_busy    (q_b_busy),
      .w_en        (w_en),
      .w_addr      (w_addr),
      .w_data      (w_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      wb.req_valid = 2'b11;
      wb.req_addr  = {4'd2, 4'd1};
      wb.req_data  = {32'h0000_000B, 32'h0000_000A};
      sb_set_en    = 1'b0;
      sb_set_addr  = '0;
      q_a_addr     = 4'd1;
      q_b_addr     = 4'd2;
      step();
      step();
      checks++;
      if (w_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_w_en got=%b exp=0", w_en);
      end
      checks++;
      if (w_addr !== 4'd0 || w_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_w_bus got=%h/%h exp=0/0", w_addr, w_data);
      end
      checks++;
      if (q_a_busy !== 1'b0 || q_b_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b%b exp=00", q_a_busy, q_b_busy);
      end
      rst = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         checks++;
         if (wb.req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_ready[%0d] got=%b exp=%b",
                     k, wb.req_ready, exp_rdy);
         end
         step();
         checks++;
         if (w_en !== 1'b1 || w_addr !== reg_addr_t'(k % 2 + 1)) begin
            errors++;
            $display("FAIL rr_write[%0d] got=%b/%0d exp=1/%0d",
                     k, w_en, w_addr, k % 2 + 1);
         end
      end
      wb.req_valid = 2'b00;
      step();
      checks++;
      if (w_en !== 1'b0) begin
         errors++;
         $display("FAIL rr_idle got=%b exp=0", w_en);
      end
   endtask

   task automatic test_single_write();
      wb.req_valid = 2'b01;
      wb.req_addr  = {4'd0, 4'd5};
      wb.req_data  = {32'h0, 32'hDEADBEEF};
      #1;
      checks++;
      if (wb.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_ready got=%b exp=01", wb.req_ready);
      end
      step();
      wb.req_valid = 2'b00;
      checks++;
      if (w_en !== 1'b1 || w_addr !== 4'd5 || w_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef",
                  w_en, w_addr, w_data);
      end
      step();
      checks++;
      if (w_en !== 1'b0 || w_addr !== 4'd5 || w_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef",
                  w_en, w_addr, w_data);
      end
   endtask

   task automatic test_scoreboard();
      sb_set_en   = 1'b1;
      sb_set_addr = 4'd7;
      #1;
      checks++;
      if (sb_set_rdy !== 1'b1) begin
         errors++;
         $display("FAIL sb_claim_rdy got=%b exp=1", sb_set_rdy);
      end
      step();
      q_a_addr = 4'd7;
      q_b_addr = 4'd6;
      #1;
      checks++;
      if (q_a_busy !== 1'b1 || q_b_busy !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy7 got=%b%b exp=10", q_a_busy, q_b_busy);
      end
      checks++;
      if (sb_set_rdy !== 1'b0) begin
         errors++;
         $display("FAIL sb_waw_stall got=%b exp=0", sb_set_rdy);
      end
      step();
      sb_set_en    = 1'b0;
      wb.req_valid = 2'b10;
      wb.req_addr  = {4'd7, 4'd0};
      wb.req_data  = {32'h0000_0077, 32'h0};
      step();
      wb.req_valid = 2'b00;
      checks++;
      if (w_en !== 1'b1 || w_addr !== 4'd7 || q_a_busy !== 1'b1) begin
         errors++;
         $display("FAIL sb_wb7 got=%b/%0d/%b exp=1/7/1",
                  w_en, w_addr, q_a_busy);
      end
      step();
      checks++;
      if (q_a_busy !== 1'b0) begin
         errors++;
         $display("FAIL sb_clear7 got=%b exp=0", q_a_busy);
      end
   endtask

   task automatic test_set_clear_same();
      wb.req_valid = 2'b01;
      wb.req_addr  = {4'd0, 4'd3};
      wb.req_data  = {32'h0, 32'h0000_0033};
      step();
      wb.req_valid = 2'b00;
      sb_set_en    = 1'b1;
      sb_set_addr  = 4'd3;
      #1;
      checks++;
      if (w_en !== 1'b1 || w_addr !== 4'd3 || sb_set_rdy !== 1'b1) begin
         errors++;
         $display("FAIL sc_setup got=%b/%0d/%b exp=1/3/1",
                  w_en, w_addr, sb_set_rdy);
      end
      step();
      sb_set_en = 1'b0;
      q_a_addr  = 4'd3;
      #1;
      checks++;
      if (q_a_busy !== 1'b1) begin
         errors++;
         $display("FAIL sc_set_wins got=%b exp=1", q_a_busy);
      end
   endtask

   task automatic test_addr_zero();
      wb.req_valid = 2'b10;
      wb.req_addr  = {4'd0, 4'd0};
      wb.req_data  = {32'h0000_0001, 32'h0};
      #1;
      checks++;
      if (wb.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL x0_ready got=%b exp=10", wb.req_ready);
      end
      step();
      wb.req_valid = 2'b00;
      checks++;
      if (w_en !== 1'b0) begin
         errors++;
         $display("FAIL x0_no_write got=%b exp=0", w_en);
      end
      sb_set_en   = 1'b1;
      sb_set_addr = 4'd0;
      #1;
      checks++;
      if (sb_set_rdy !== 1'b1) begin
         errors++;
         $display("FAIL x0_set_rdy got=%b exp=1", sb_set_rdy);
      end
      step();
      sb_set_en = 1'b0;
      q_a_addr  = 4'd0;
      q_b_addr  = 4'd0;
      #1;
      checks++;
      if (q_a_busy !== 1'b0 || q_b_busy !== 1'b0) begin
         errors++;
         $display("FAIL x0_busy got=%b%b exp=00", q_a_busy, q_b_busy);
      end
   endtask

   task automatic test_async_reset();
      sb_set_en    = 1'b1;
      sb_set_addr  = 4'd9;
      wb.req_valid = 2'b01;
      wb.req_addr  = {4'd0, 4'd4};
      wb.req_data  = {32'h0, 32'h0000_0044};
      step();
      sb_set_en    = 1'b0;
      wb.req_valid = 2'b00;
      q_a_addr     = 4'd9;
      q_b_addr     = 4'd3;
      #1;
      checks++;
      if (w_en !== 1'b1 || q_a_busy !== 1'b1 || q_b_busy !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre got=%b/%b/%b exp=1/1/1",
                  w_en, q_a_busy, q_b_busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (w_en !== 1'b0 || w_addr !== 4'd0) begin
         errors++;
         $display("FAIL ar_w_drop got=%b/%0d exp=0/0", w_en, w_addr);
      end
      checks++;
      if (q_a_busy !== 1'b0 || q_b_busy !== 1'b0) begin
         errors++;
         $display("FAIL ar_busy got=%b%b exp=00", q_a_busy, q_b_busy);
      end
      step();
      rst = 1'b1;
      step();
      checks++;
      if (w_en !== 1'b0 || q_a_busy !== 1'b0) begin
         errors++;
         $display("FAIL ar_after got=%b/%b exp=0/0", w_en, q_a_busy);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_write();
      test_scoreboard();
      test_set_clear_same();
      test_addr_zero();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
